// File: rtl/int_fix_lane_pipe.sv
// int_fix_lane_pipe
//   Three-stage valid/ready pipeline that adds a signed integer A to a signed
//   fixed-point B, then produces NLANES results S*MUL[k] + ADD[k]. Each result
//   is rounded half toward +inf and saturated to the signed DW range. MUL/ADD
//   are runtime-programmable per lane.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   IN_VALID/IN_READY   input handshake, A (IW bits int), B (DW bits fixed)
//   CFG_WE/LANE/SEL/DATA coefficient write port (SEL 0 = MUL, 1 = ADD)
//   OUT_VALID/OUT_READY output handshake
//   XOUT                lane k at [k*DW +: DW], signed Q(IW).(FW)
//   SAT                 per-lane clamp flag for the current result
//   BUSY                any stage holds a valid sample
module int_fix_lane_pipe #(
    parameter int IW     = 32,
    parameter int FW     = 16,
    parameter int NLANES = 4,
    localparam int DW    = IW + FW,
    localparam int LW    = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [IW-1:0]        A,
    input  logic [DW-1:0]        B,
    input  logic                 CFG_WE,
    input  logic [LW-1:0]        CFG_LANE,
    input  logic                 CFG_SEL,
    input  logic [DW-1:0]        CFG_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [NLANES*DW-1:0] XOUT,
    output logic [NLANES-1:0]    SAT,
    output logic                 BUSY
);

    localparam int SW = DW + 1;        // stage-1 sum width, cannot overflow
    localparam int PW = 2 * DW + 1;    // full-precision product width
    localparam int RW = PW - FW;       // rounded product width
    localparam int TW = RW + 1;        // rounded product plus offset

    localparam logic [DW-1:0] MUL_ONE = DW'(1) << FW;
    localparam logic [PW-1:0] HALF    = PW'(1) << (FW - 1);

    // Whole pipeline moves together; a stalled output freezes every stage,
    // so bubbles stay where they are.
    logic en;
    assign en       = !OUT_VALID | OUT_READY;
    assign IN_READY = en;

    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [SW-1:0] s_q, s_d;

    always_comb begin
        v1_d        = v1_q;
        v2_d        = v2_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        if (en) begin
            v1_d        = IN_VALID;
            v2_d        = v1_q;
            out_valid_d = v2_q;
            if (IN_VALID) begin
                s_d = ($signed({{(SW-IW){A[IW-1]}}, A}) <<< FW)
                    + $signed({{(SW-DW){B[DW-1]}}, B});
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign BUSY      = v1_q | v2_q | out_valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [DW-1:0]        mul_q, mul_d;
            logic [DW-1:0]        add_q, add_d;
            logic signed [RW-1:0] r_q, r_d;
            logic [DW-1:0]        x_q, x_d;
            logic                 sat_q, sat_d;
            logic                 hit;
            logic signed [PW-1:0] p;
            logic signed [PW-1:0] p_rnd;
            logic signed [TW-1:0] t;
            logic                 frac_unused;

            // Lane indices that do not exist never match, so such writes
            // fall on the floor without extra logic.
            always_comb begin
                hit   = CFG_WE && (CFG_LANE == LW'(gi));
                mul_d = mul_q;
                add_d = add_q;
                if (hit && !CFG_SEL) mul_d = CFG_DATA;
                if (hit &&  CFG_SEL) add_d = CFG_DATA;
            end

            // Stage 2: product, then add half an LSB and drop FW bits, which
            // is the same as an arithmetic shift followed by truncation.
            always_comb begin
                p     = $signed({{(PW-SW){s_q[SW-1]}}, s_q})
                      * $signed({{(PW-DW){mul_q[DW-1]}}, mul_q});
                p_rnd = p + $signed(HALF);
                r_d   = r_q;
                if (en && v1_q) r_d = p_rnd[PW-1:FW];
            end
            assign frac_unused = ^p_rnd[FW-1:0];

            // Stage 3: offset and clamp. The value fits in DW bits exactly
            // when every bit from DW-1 upward equals the sign bit.
            always_comb begin
                t     = $signed({{(TW-RW){r_q[RW-1]}}, r_q})
                      + $signed({{(TW-DW){add_q[DW-1]}}, add_q});
                x_d   = x_q;
                sat_d = sat_q;
                if (en && v2_q) begin
                    if (t[TW-1:DW-1] == {(TW-DW+1){t[TW-1]}}) begin
                        x_d   = t[DW-1:0];
                        sat_d = 1'b0;
                    end else begin
                        x_d   = t[TW-1] ? {1'b1, {(DW-1){1'b0}}}
                                        : {1'b0, {(DW-1){1'b1}}};
                        sat_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    mul_q <= MUL_ONE;
                    add_q <= '0;
                    r_q   <= '0;
                    x_q   <= '0;
                    sat_q <= 1'b0;
                end else begin
                    mul_q <= mul_d;
                    add_q <= add_d;
                    r_q   <= r_d;
                    x_q   <= x_d;
                    sat_q <= sat_d;
                end
            end

            assign XOUT[gi*DW +: DW] = x_q;
            assign SAT[gi]           = sat_q;
        end
    endgenerate

endmodule

// File: tb/tb_int_fix_lane_pipe.sv
// Scoreboard bench for int_fix_lane_pipe. A second instance with five lanes
// (3-bit lane select) receives the same samples, keeps default coefficients
// and is used to probe writes to nonexistent lanes.
module tb_int_fix_lane_pipe;
    localparam int DW  = 48;
    localparam int NL  = 4;
    localparam int NL2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   a = '0;
    logic [47:0]   b = '0;
    logic          cfg_we = 1'b0;
    logic          cfg_we2 = 1'b0;
    logic [1:0]    cfg_lane = '0;
    logic [2:0]    cfg_lane2 = '0;
    logic          cfg_sel = 1'b0;
    logic [47:0]   cfg_data = '0;
    logic          out_ready = 1'b1;

    logic              in_ready, out_valid, busy;
    logic [NL*DW-1:0]  xout;
    logic [NL-1:0]     sat;
    logic              in_ready2, out_valid2, busy2;
    logic [NL2*DW-1:0] xout2;
    logic [NL2-1:0]    sat2;

    int_fix_lane_pipe #(.IW(32), .FW(16), .NLANES(NL)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CFG_WE(cfg_we), .CFG_LANE(cfg_lane), .CFG_SEL(cfg_sel),
        .CFG_DATA(cfg_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .XOUT(xout), .SAT(sat), .BUSY(busy)
    );

    int_fix_lane_pipe #(.IW(32), .FW(16), .NLANES(NL2)) dut2 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready2),
        .A(a), .B(b), .CFG_WE(cfg_we2), .CFG_LANE(cfg_lane2), .CFG_SEL(cfg_sel),
        .CFG_DATA(cfg_data), .OUT_VALID(out_valid2), .OUT_READY(out_ready),
        .XOUT(xout2), .SAT(sat2), .BUSY(busy2)
    );

    typedef struct {
        logic [NL*DW-1:0] x;
        logic [NL-1:0]    s;
    } exp_t;

    exp_t        q1[$];
    logic [47:0] q2[$];
    int checks   = 0;
    int errors   = 0;
    int accepted = 0;
    int txn      = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compare the head of each queue whenever a result is presented
    // (also while stalled, which checks the hold); pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_lockstep", 256'(out_valid2), 256'(out_valid));
            if (out_valid) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got xout=%h with no expected entry", xout);
                end else begin
                    check("xout", 256'(xout), 256'(q1[0].x));
                    check("sat", 256'(sat), 256'(q1[0].s));
                    if (out_ready) begin
                        txn++;
                        $display("txn %0d: x0=%0d x1=%0d x2=%0d x3=%0d sat=%b", txn,
                                 $signed(xout[0*DW +: DW]), $signed(xout[1*DW +: DW]),
                                 $signed(xout[2*DW +: DW]), $signed(xout[3*DW +: DW]), sat);
                        void'(q1.pop_front());
                    end
                end
            end
            if (out_valid2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output2: got xout2=%h with no expected entry", xout2);
                end else begin
                    check("xout2", 256'(xout2), 256'({NL2{q2[0]}}));
                    check("sat2", 256'(sat2), 256'(0));
                    if (out_ready) void'(q2.pop_front());
                end
            end
        end
    end

    // Offer one sample and push its hand-computed results once accepted.
    task automatic send(input logic [31:0] av, input logic [47:0] bv,
                        input logic [47:0] e0, input logic [47:0] e1,
                        input logic [47:0] e2, input logic [47:0] e3,
                        input logic [3:0] es, input logic [47:0] ed);
        exp_t e;
        int n = 0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        e.x      = {e3, e2, e1, e0};
        e.s      = es;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            q1.push_back(e);
            q2.push_back(ed);
            accepted++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] lane, input logic sel, input logic [47:0] data);
        cfg_lane = lane;
        cfg_sel  = sel;
        cfg_data = data;
        cfg_we   = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write2(input logic [2:0] lane, input logic sel, input logic [47:0] data);
        cfg_lane2 = lane;
        cfg_sel   = sel;
        cfg_data  = data;
        cfg_we2   = 1'b1;
        @(posedge clk);
        #1;
        cfg_we2 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0 || busy || busy2) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_busy", 256'(busy), 256'(0));
        check("drain_queue", 256'(q1.size()), 256'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc0;
        do_reset();

        // Reset state
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_xout", 256'(xout), 256'(0));
        check("rst_sat", 256'(sat), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // Default coefficients: 3 + 0.5 = 3.5 on every lane, plus latency
        send(32'd3, 48'h8000, 229376, 229376, 229376, 229376, 4'b0000, 229376);
        check("lat_after_accept", 256'(out_valid), 256'(0));
        @(posedge clk); #1;
        check("lat_plus1", 256'(out_valid), 256'(0));
        @(posedge clk); #1;
        check("lat_plus2", 256'(out_valid), 256'(1));
        drain();

        // Programmed lanes
        cfg_write(2'd0, 1'b0, 48'h110000);
        cfg_write(2'd0, 1'b1, -205783);
        cfg_write(2'd1, 1'b0, 3121);
        cfg_write(2'd1, 1'b1, 178145);
        cfg_write(2'd2, 1'b0, 65536);
        cfg_write(2'd2, 1'b1, 196608);
        send(32'd3, 48'h8000, 3693609, 189069, 425984, 229376, 4'b0000, 229376);
        drain();

        // Reset with three samples in flight
        send(32'd3, 48'h8000, 3693609, 189069, 425984, 229376, 4'b0000, 229376);
        send(32'd3, 48'h8000, 3693609, 189069, 425984, 229376, 4'b0000, 229376);
        send(32'd3, 48'h8000, 3693609, 189069, 425984, 229376, 4'b0000, 229376);
        check("midop_busy_before", 256'(busy), 256'(1));
        rst = 1'b1;
        #1;
        check("midop_out_valid", 256'(out_valid), 256'(0));
        check("midop_busy", 256'(busy), 256'(0));
        check("midop_xout", 256'(xout), 256'(0));
        q1.delete();
        q2.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(32'd3, 48'h8000, 229376, 229376, 229376, 229376, 4'b0000, 229376);
        drain();

        // Saturation, positive and negative, lane 0 at 2.0
        cfg_write(2'd0, 1'b0, 48'h20000);
        send(32'h7FFFFFFF, 48'h0, 48'h7FFFFFFFFFFF, 48'h7FFFFFFF0000, 48'h7FFFFFFF0000,
             48'h7FFFFFFF0000, 4'b0001, 48'h7FFFFFFF0000);
        send(32'h80000000, 48'h0, 48'h800000000000, 48'h800000000000, 48'h800000000000,
             48'h800000000000, 4'b0001, 48'h800000000000);

        // Rounding around one half LSB, lane 3 at raw MUL = 1 (2^-16)
        drain();
        cfg_write(2'd3, 1'b0, 48'h1);
        send(32'd0, 48'h8000, 65536, 32768, 32768, 1, 4'b0000, 32768);
        send(32'd0, 48'h7FFF, 65534, 32767, 32767, 0, 4'b0000, 32767);
        send(32'd0, -32768, -65536, -32768, -32768, 0, 4'b0000, -32768);
        send(32'd0, -32769, -65538, -32769, -32769, -1, 4'b0000, -32769);
        drain();

        // Writes to nonexistent lanes of the five-lane instance are ignored
        do_reset();
        cfg_write2(3'd5, 1'b0, 48'h123456);
        cfg_write2(3'd5, 1'b1, 48'h777777);
        cfg_write2(3'd7, 1'b0, 48'h0);
        cfg_write2(3'd6, 1'b1, 48'h10000);
        send(-2, 48'h4000, -114688, -114688, -114688, -114688, 4'b0000, -114688);
        drain();

        // Backpressure: five offered, three accepted, release with no gaps
        out_ready = 1'b0;
        acc0 = accepted;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send(k, 48'h0, 65536 * k, 65536 * k, 65536 * k, 65536 * k, 4'b0000, 65536 * k);
            end
        join_none
        repeat (8) @(posedge clk);
        #1;
        check("bp_accepted", 256'(accepted - acc0), 256'(3));
        check("bp_in_ready", 256'(in_ready), 256'(0));
        check("bp_out_valid", 256'(out_valid), 256'(1));
        check("bp_hold_x0", 256'(xout[DW-1:0]), 256'(65536));
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_no_gap", 256'(out_valid), 256'(1));
        end
        wait fork;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
